// File: rtl/prime_scan_ctrl.sv
// prime_scan_ctrl: sweeps a BCD digit range [lo, hi] through an external
// combinational prime checker, one digit per clock, and collects a prime
// mask and prime count. Latency start->done: hi-lo+2 cycles (1 if invalid).
// Backpressure: none; start is only sampled in IDLE and is never queued.
module prime_scan_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] lo,
    input  logic [3:0] hi,
    output logic [3:0] chk_in,
    input  logic       chk_out,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] count,
    output logic [9:0] mask
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] hi_q;     // last digit of the scan, inclusive
    logic       req_bad;

    // A request is unusable if either bound is not a BCD digit or the range is empty.
    assign req_bad = (lo > 4'd9) || (hi > 4'd9) || (lo > hi);

    // Scan FSM. chk_in doubles as the current-digit register: it holds the
    // digit under test in SCAN and is forced to 0 everywhere else, so the
    // checker sees a registered, glitch-free input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            hi_q   <= 4'd0;
            chk_in <= 4'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            count  <= 4'd0;
            mask   <= 10'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        hi_q  <= hi;
                        count <= 4'd0;
                        mask  <= 10'd0;
                        if (req_bad) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            err    <= 1'b0;
                            busy   <= 1'b1;
                            chk_in <= lo;
                            state  <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    // chk_in never exceeds 9 here, so the index is always in range
                    // and the count (at most 10 increments) cannot overflow.
                    mask[chk_in] <= chk_out;
                    count        <= count + {3'b000, chk_out};
                    if (chk_in == hi_q) begin
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        chk_in <= 4'd0;
                        state  <= DONE;
                    end else begin
                        chk_in <= chk_in + 4'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    chk_in <= 4'd0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Bench for prime_scan_ctrl: a behavioural checker table stands in for the
// external prime block; results are compared against a range/loop model.
module tb_prime_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] lo = 4'd0;
    logic [3:0] hi = 4'd0;
    logic [3:0] chk_in;
    logic       chk_out;
    logic       busy, done, err;
    logic [3:0] count;
    logic [9:0] mask;

    logic [9:0] tbl;          // checker answer for each digit
    logic [9:0] prime_tbl;
    int         n_pass = 0;
    int         n_tot  = 0;

    always #5 clk = ~clk;

    prime_scan_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .lo     (lo),
        .hi     (hi),
        .chk_in (chk_in),
        .chk_out(chk_out),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .count  (count),
        .mask   (mask)
    );

    // Combinational stand-in for the external prime checker.
    assign chk_out = (chk_in <= 4'd9) ? tbl[chk_in] : 1'b0;

    function automatic bit is_prime(int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++)
            if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Issues one request and checks the whole transaction against the model.
    task automatic scan(input logic [3:0] l, input logic [3:0] h, input bit hold, input string name);
        bit         valid;
        int         exp_lat, exp_nb, got_lat, nb, seq_bad;
        logic [3:0] exp_cnt, got_cnt;
        logic [9:0] exp_msk, got_msk;
        logic       got_err;

        valid   = (l <= 9) && (h <= 9) && (l <= h);
        exp_cnt = 4'd0;
        exp_msk = 10'd0;
        if (valid) begin
            for (int d = int'(l); d <= int'(h); d++) begin
                exp_msk[d] = tbl[d];
                exp_cnt    = exp_cnt + 4'(tbl[d]);
            end
            exp_lat = int'(h) - int'(l) + 2;
            exp_nb  = exp_lat - 1;
        end else begin
            exp_lat = 1;
            exp_nb  = 0;
        end

        @(negedge clk);            // cycle 0
        lo = l; hi = h; start = 1'b1;
        got_lat = 0; nb = 0; seq_bad = 0;
        got_cnt = 4'd0; got_msk = 10'd0; got_err = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (busy) begin
                if (int'(chk_in) != int'(l) + nb) seq_bad++;
                nb++;
            end else if (chk_in != 4'd0) begin
                seq_bad++;
            end
            if (done) begin
                got_lat = c;
                got_cnt = count;
                got_msk = mask;
                got_err = err;
                break;
            end
        end
        check({name, " latency"}, got_lat, exp_lat);
        check({name, " count"},   got_cnt, exp_cnt);
        check({name, " mask"},    got_msk, exp_msk);
        check({name, " err"},     got_err, !valid);
        check({name, " busy_cycles"}, nb, exp_nb);
        check({name, " chk_in_seq_errors"}, seq_bad, 0);
        // First cycle back in IDLE: pulse gone, results held.
        @(negedge clk);
        start = 1'b0;
        check({name, " hold"}, {done, busy, err, count, mask}, {1'b0, 1'b0, !valid, exp_cnt, exp_msk});
    endtask

    typedef struct {
        logic [3:0] lo;
        logic [3:0] hi;
        bit         hold;
        string      name;
    } vec_t;

    initial begin
        vec_t vecs[10];
        int   ndone;

        for (int d = 0; d < 10; d++) prime_tbl[d] = is_prime(d);
        tbl = prime_tbl;

        vecs[0] = '{4'd0,  4'd9,  1'b0, "full_sweep"};
        vecs[1] = '{4'd7,  4'd7,  1'b0, "single_7"};
        vecs[2] = '{4'd5,  4'd3,  1'b0, "inv_lo_gt_hi"};
        vecs[3] = '{4'd5,  4'd12, 1'b0, "inv_hi_12"};
        vecs[4] = '{4'd1,  4'd4,  1'b1, "held_start"};
        vecs[5] = '{4'd2,  4'd3,  1'b0, "range_2_3"};
        vecs[6] = '{4'd9,  4'd9,  1'b0, "single_9"};
        vecs[7] = '{4'd10, 4'd10, 1'b0, "inv_lo_10"};
        vecs[8] = '{4'd0,  4'd0,  1'b0, "single_0"};
        vecs[9] = '{4'd2,  4'd2,  1'b0, "single_2"};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst chk_in", chk_in, 0);
        check("rst busy",   busy,   0);
        check("rst done",   done,   0);
        check("rst err",    err,    0);
        check("rst count",  count,  0);
        check("rst mask",   mask,   0);
        rst = 1'b0;

        // Directed vectors with the real prime table.
        for (int i = 0; i < 10; i++) scan(vecs[i].lo, vecs[i].hi, vecs[i].hold, vecs[i].name);

        // Spec-stated full-sweep values, independent of the model.
        check("prime_tbl", prime_tbl, 10'h0AC);

        // start held high across a 1..4 scan, then into IDLE.
        @(negedge clk);
        lo = 4'd1; hi = 4'd4; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c < 5) check("held busy", {busy, done}, 2'b10);
        end
        check("held done", {done, busy, err, count, mask}, {1'b1, 1'b0, 1'b0, 4'd2, 10'h00C});
        @(negedge clk);            // cycle 6: IDLE, start accepted here
        check("held idle_stable", {done, busy, count, mask}, {1'b0, 1'b0, 4'd2, 10'h00C});
        @(negedge clk);            // cycle 7: second scan running
        start = 1'b0;
        check("held reaccept", {busy, count, chk_in}, {1'b1, 4'd0, 4'd1});
        ndone = 0;
        for (int c = 0; c < 20 && ndone == 0; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("held second_done", ndone, 1);
        @(negedge clk);

        // Reset asserted in cycle 4 of a full sweep.
        @(negedge clk);
        lo = 4'd0; hi = 4'd9; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;   // cycle 4
        @(negedge clk);
        check("midrst outputs", {chk_in, busy, done, err, count, mask}, 22'd0);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("midrst no_done", ndone, 0);
        scan(4'd2, 4'd3, 1'b0, "after_rst");

        // Random requests against a random checker table.
        for (int i = 0; i < 40; i++) begin
            tbl = 10'($urandom);
            scan(4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)), bit'($urandom_range(0, 1)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
